// File: rtl/core_exec_sequencer.sv
// ============================================================================
// Module      : core_exec_sequencer
// Description : Core-side run sequencer. On a rising edge of cexec it fetches
//               instruction words from cmem_addr upward over a req/ack memory
//               port and presents them to the core on a valid/ready handshake.
//               It tracks run/halt/timeout state and reports it on cstat.
// Ports       : cclk/crstn        clock, asynchronous active-low reset
//               crst              synchronous soft reset (active-high)
//               cexec/cmem_addr   run request level and start address
//               cstat             {2'b0, error, halted, busy, state[2:0]}
//               mem_req/mem_addr  fetch request (held until mem_ack)
//               mem_ack/mem_rdata one-cycle acknowledge and fetched word
//               inst_valid/inst_data/inst_ready  instruction handshake
//               core_halt         core halt indication
//               perf_cnt          retired-word count
// Options     : CORE_EXEC_PERF_EN enables the saturating retired-word counter;
//               without it perf_cnt is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module core_exec_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_STEP      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  cclk,
    input  logic                  crstn,
    input  logic                  crst,
    input  logic                  cexec,
    input  logic [ADDR_WIDTH-1:0] cmem_addr,
    output logic [7:0]            cstat,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready,
    input  logic                  core_halt,
    output logic [31:0]           perf_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // Counter only needs to reach TIMEOUT_CYCLES-1: the cycle that finds it
    // there without an ack is the last cycle the request is held.
    localparam int                    TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]         TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(ADDR_STEP);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [TW-1:0]         tcnt;
    logic                  cexec_q;

    // ------------------------------------------------------------------
    // Next-state logic. Priority inside FETCH/ISSUE: halt > ack > timeout.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            ST_IDLE: begin
                if (cexec && !cexec_q) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = cmem_addr;
                end
            end
            ST_FETCH: begin
                if (core_halt)         state_nxt = ST_HALTED;
                else if (mem_ack)      state_nxt = ST_ISSUE;
                else if (tcnt == TLAST) state_nxt = ST_ERROR;
            end
            ST_ISSUE: begin
                // inst_valid is always high in ISSUE, so ready alone is the handshake.
                if (inst_ready) begin
                    pc_nxt = pc + STEP;
                    if (core_halt)  state_nxt = ST_HALTED;
                    else if (cexec) state_nxt = ST_FETCH;
                    else            state_nxt = ST_IDLE;
                end else if (core_halt) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: if (!cexec) state_nxt = ST_IDLE;
            ST_ERROR:  if (!cexec) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs; outputs are decoded from the next state
    // so each one is a flop with no input-to-output combinational path.
    // ------------------------------------------------------------------
    always_ff @(posedge cclk or negedge crstn) begin
        if (!crstn) begin
            state      <= ST_IDLE;
            pc         <= '0;
            tcnt       <= '0;
            cexec_q    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            cstat      <= 8'h00;
        end else if (crst) begin
            state      <= ST_IDLE;
            pc         <= '0;
            tcnt       <= '0;
            cexec_q    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            cstat      <= 8'h00;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            cexec_q    <= cexec;
            tcnt       <= (state == ST_FETCH && state_nxt == ST_FETCH) ? tcnt + TW'(1) : '0;
            mem_req    <= (state_nxt == ST_FETCH);
            mem_addr   <= pc_nxt;
            inst_valid <= (state_nxt == ST_ISSUE);
            if (state == ST_FETCH && state_nxt == ST_ISSUE) begin
                inst_data <= mem_rdata;
            end
            cstat      <= {2'b00,
                           state_nxt == ST_ERROR,
                           state_nxt == ST_HALTED,
                           state_nxt == ST_FETCH || state_nxt == ST_ISSUE,
                           state_nxt};
        end
    end

`ifdef CORE_EXEC_PERF_EN
    logic launch;
    logic retire;

    assign launch = (state == ST_IDLE) && (state_nxt == ST_FETCH);
    assign retire = (state == ST_ISSUE) && inst_ready;

    always_ff @(posedge cclk or negedge crstn) begin
        if (!crstn) begin
            perf_cnt <= 32'h0;
        end else if (crst || launch) begin
            perf_cnt <= 32'h0;
        end else if (retire && perf_cnt != 32'hFFFF_FFFF) begin
            perf_cnt <= perf_cnt + 32'h1;
        end
    end
`else
    assign perf_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_exec_sequencer.sv
// ============================================================================
// Module      : tb_core_exec_sequencer
// Description : Scoreboard bench for core_exec_sequencer. Stimulus pushes the
//               expected fetch addresses; the memory responder checks them and
//               pushes the returned words; the core-side monitor checks words.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_core_exec_sequencer;

`ifdef CORE_EXEC_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        cclk = 1'b0;
    logic        crstn, crst, cexec;
    logic [31:0] cmem_addr;
    logic [7:0]  cstat;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        core_halt;
    logic [31:0] perf_cnt;

    core_exec_sequencer dut (
        .cclk       (cclk),
        .crstn      (crstn),
        .crst       (crst),
        .cexec      (cexec),
        .cmem_addr  (cmem_addr),
        .cstat      (cstat),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .core_halt  (core_halt),
        .perf_cnt   (perf_cnt)
    );

    always #5 cclk = ~cclk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_inst[$];
    int          hs_count    = 0;
    int          halt_at     = -1;
    int          bp_cnt      = 0;
    int          wait_cnt    = 0;
    int          fixed_delay = -1;
    bit          rsp_en      = 1'b1;
    bit          use_fixed   = 1'b0;
    logic [31:0] fixed_data  = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after a delay, checks the request address
    // against the scoreboard and records the word it returns.
    initial begin : responder
        logic [31:0] d;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge cclk);
            mem_ack = 1'b0;
            if (crstn && mem_req && rsp_en) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    d = use_fixed ? fixed_data : $urandom;
                    use_fixed = 1'b0;
                    mem_ack   = 1'b1;
                    mem_rdata = d;
                    if (exp_addr.size() == 0) chk("unexpected_fetch", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    else                      chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
                    exp_inst.push_back(d);
                    wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
            end
        end
    end

    // Core-side monitor: drives ready, checks delivered words and hold behaviour.
    initial begin : consumer
        bit          prev_valid = 1'b0;
        bit          prev_hs    = 1'b0;
        logic [31:0] prev_data  = 32'h0;
        inst_ready = 1'b0;
        core_halt  = 1'b0;
        forever begin
            @(negedge cclk);
            core_halt = 1'b0;
            if (!crstn) begin
                inst_ready = 1'b0;
            end else if (inst_valid) begin
                if (prev_valid && !prev_hs) chk("inst_hold", 64'(inst_data), 64'(prev_data));
                if (bp_cnt > 0) begin
                    inst_ready = 1'b0;
                    bp_cnt--;
                end else begin
                    inst_ready = ($urandom_range(0, 3) != 0);
                end
                if (inst_ready) begin
                    if (exp_inst.size() == 0) chk("unexpected_inst", 64'(inst_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    else                      chk("inst_data", 64'(inst_data), 64'(exp_inst.pop_front()));
                    if (hs_count == halt_at) core_halt = 1'b1;
                    hs_count++;
                end else begin
                    chk("no_fetch_while_stalled", 64'(mem_req), 64'h0);
                end
            end else begin
                inst_ready = 1'(($urandom_range(0, 1)));
            end
            prev_valid = crstn && inst_valid;
            prev_hs    = inst_valid && inst_ready;
            prev_data  = inst_data;
        end
    end

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(negedge cclk);
            #1;
            n++;
        end
        if (hs_count < target) chk("handshake_wait_expired", 64'(hs_count), 64'(target));
    endtask

    // One run of n words from start; cexec drops once word n is in flight.
    task automatic run(input logic [31:0] start, input int n, input int bp, input bit chk_launch);
        for (int k = 0; k < n; k++) exp_addr.push_back(start + 32'(4 * k));
        hs_count = 0;
        bp_cnt   = bp;
        @(posedge cclk);
        #1;
        cmem_addr = start;
        cexec     = 1'b1;
        @(posedge cclk);
        #1;
        if (n == 1) cexec = 1'b0;
        if (chk_launch) begin
            @(negedge cclk);
            chk("launch_cstat", 64'(cstat), 64'h09);
            chk("launch_mem_req", 64'(mem_req), 64'h1);
        end
        if (n > 1) begin
            wait_hs(n - 1, 400);
            @(posedge cclk);
            #1;
            cexec = 1'b0;
        end
        wait_hs(n, 400);
        @(posedge cclk);
        @(negedge cclk);
        chk("run_end_cstat", 64'(cstat), 64'h00);
        chk("run_end_mem_req", 64'(mem_req), 64'h0);
        chk("run_end_inst_valid", 64'(inst_valid), 64'h0);
        chk("run_end_perf", 64'(perf_cnt), PERF_ON ? 64'(n) : 64'h0);
        chk("run_end_queues", 64'(exp_addr.size() + exp_inst.size()), 64'h0);
    endtask

    initial begin : stimulus
        int cnt;
        crstn     = 1'b0;
        crst      = 1'b0;
        cexec     = 1'b0;
        cmem_addr = 32'h0;
        repeat (3) @(posedge cclk);
        #1;
        chk("reset_cstat", 64'(cstat), 64'h00);
        chk("reset_mem_req", 64'(mem_req), 64'h0);
        chk("reset_inst_valid", 64'(inst_valid), 64'h0);
        chk("reset_mem_addr", 64'(mem_addr), 64'h0);
        chk("reset_perf", 64'(perf_cnt), 64'h0);
        crstn = 1'b1;

        // Launch at 0x1000, ack two cycles later with 0xDEADBEEF, 5-cycle stall.
        fixed_delay = 2;
        wait_cnt    = 2;
        use_fixed   = 1'b1;
        fixed_data  = 32'hDEAD_BEEF;
        run(32'h0000_1000, 2, 5, 1'b1);
        fixed_delay = -1;

        // Address wrap.
        run(32'hFFFF_FFFC, 2, 0, 1'b0);

        // Timeout: never ack.
        rsp_en = 1'b0;
        @(posedge cclk);
        #1;
        cmem_addr = 32'h0000_3000;
        cexec     = 1'b1;
        cnt       = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge cclk);
            if (mem_req) cnt++;
            else if (cnt > 0) break;
        end
        chk("timeout_req_cycles", 64'(cnt), 64'd256);
        chk("timeout_cstat", 64'(cstat), 64'h24);
        #1;
        cexec = 1'b0;
        @(negedge cclk);
        chk("error_exit_cstat", 64'(cstat), 64'h00);

        // Halt together with the 4th handshake.
        rsp_en   = 1'b1;
        wait_cnt = 0;
        for (int k = 0; k < 4; k++) exp_addr.push_back(32'h2000 + 32'(4 * k));
        hs_count = 0;
        halt_at  = 3;
        @(posedge cclk);
        #1;
        cmem_addr = 32'h0000_2000;
        cexec     = 1'b1;
        wait_hs(4, 400);
        @(posedge cclk);
        @(negedge cclk);
        halt_at = -1;
        chk("halt_cstat", 64'(cstat), 64'h13);
        chk("halt_perf", 64'(perf_cnt), PERF_ON ? 64'd4 : 64'h0);
        chk("halt_mem_req", 64'(mem_req), 64'h0);
        #1;
        cexec = 1'b0;
        @(negedge cclk);
        chk("halt_exit_cstat", 64'(cstat), 64'h00);

        // Soft reset while fetching.
        rsp_en = 1'b0;
        @(posedge cclk);
        #1;
        cmem_addr = 32'h0000_4000;
        cexec     = 1'b1;
        repeat (3) @(posedge cclk);
        #1;
        crst  = 1'b1;
        cexec = 1'b0;
        @(posedge cclk);
        #1;
        crst = 1'b0;
        chk("crst_cstat", 64'(cstat), 64'h00);
        chk("crst_mem_req", 64'(mem_req), 64'h0);

        // Asynchronous reset mid-FETCH takes effect without a clock edge.
        @(posedge cclk);
        #1;
        cexec = 1'b1;
        repeat (3) @(posedge cclk);
        #3;
        chk("pre_reset_mem_req", 64'(mem_req), 64'h1);
        crstn = 1'b0;
        #1;
        chk("async_reset_mem_req", 64'(mem_req), 64'h0);
        chk("async_reset_inst_valid", 64'(inst_valid), 64'h0);
        chk("async_reset_cstat", 64'(cstat), 64'h00);
        cexec = 1'b0;
        @(posedge cclk);
        #1;
        crstn  = 1'b1;
        rsp_en = 1'b1;

        // Randomised runs.
        for (int r = 0; r < 20; r++) begin
            logic [31:0] st;
            st       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            wait_cnt = $urandom_range(0, 3);
            run(st, $urandom_range(1, 6), $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
